// File: rtl/icache_line_fill_pkg.sv
// Shared cache defines package.
// Holds the refill line geometry, the refill FSM state type and the
// icache <-> refill interface structures used by icache_line_fill.
package icache_line_fill_pkg;

    localparam int ICACHE_LINE_WIDTH = 128;
    localparam int ICACHE_WORD_WIDTH = 32;
    localparam int ICACHE_LINE_BEATS = ICACHE_LINE_WIDTH / ICACHE_WORD_WIDTH;

    typedef enum logic [1:0] {
        IFILL_IDLE,
        IFILL_FETCH,
        IFILL_DRAIN,
        IFILL_RESP
    } type_ifill_states_e;

    // Refill request from the icache.
    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        kill;
    } type_icache2mem_s;

    // Refill response to the icache.
    typedef struct packed {
        logic [ICACHE_LINE_WIDTH-1:0] r_data;
        logic                         ack;
    } type_mem2icache_s;

endpackage

// File: rtl/icache_line_fill.sv
// icache_line_fill
// Refills one icache line by issuing ICACHE_LINE_BEATS sequential word reads
// to a downstream memory and assembling them into a line buffer.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst_n         synchronous, active-low reset
//   icache2mem_i  refill request (req, addr, kill) from the icache
//   mem2icache_o  refill response (r_data line, ack) to the icache
//   mem_req_o     downstream word read request
//   mem_addr_o    downstream word byte address
//   mem_rdata_i   downstream read data, valid with mem_ack_i
//   mem_ack_i     downstream word completion
module icache_line_fill
    import icache_line_fill_pkg::*;
#(
    parameter int LINE_WIDTH = ICACHE_LINE_WIDTH,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  type_icache2mem_s      icache2mem_i,
    output type_mem2icache_s      mem2icache_o,
    output logic                  mem_req_o,
    output logic [31:0]           mem_addr_o,
    input  logic [WORD_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i
);

    localparam logic [1:0] LAST_BEAT = 2'(ICACHE_LINE_BEATS - 1);

    type_ifill_states_e      state;
    logic [1:0]              beat;
    logic [27:0]             base;
    logic [LINE_WIDTH-1:0]   line_buf;
    logic [LINE_WIDTH-1:0]   r_data_q;
    logic                    abort;
    logic                    unused_addr_lsbs;

    // Request withdrawn or killed by the icache.
    assign abort = icache2mem_i.kill | ~icache2mem_i.req;

    // Only the line base is latched; the in-line offset is irrelevant.
    assign unused_addr_lsbs = ^icache2mem_i.addr[3:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IFILL_IDLE;
            beat      <= '0;
            base      <= '0;
            line_buf  <= '0;
            r_data_q  <= '0;
            mem_req_o <= 1'b0;
        end else begin
            case (state)
                IFILL_IDLE: begin
                    if (icache2mem_i.req && !icache2mem_i.kill) begin
                        base      <= icache2mem_i.addr[31:4];
                        beat      <= '0;
                        mem_req_o <= 1'b1;
                        state     <= IFILL_FETCH;
                    end
                end
                IFILL_FETCH: begin
                    if (abort) begin
                        // A word already issued must still complete; if it
                        // completes right now it is simply discarded.
                        if (mem_ack_i) begin
                            mem_req_o <= 1'b0;
                            state     <= IFILL_IDLE;
                        end else begin
                            state <= IFILL_DRAIN;
                        end
                    end else if (mem_ack_i) begin
                        line_buf[int'(beat)*WORD_WIDTH +: WORD_WIDTH] <= mem_rdata_i;
                        beat <= beat + 2'd1;
                        if (beat == LAST_BEAT) begin
                            // Publish the complete line, including the word
                            // arriving this cycle, so r_data only changes on
                            // delivered lines.
                            r_data_q  <= {mem_rdata_i, line_buf[LINE_WIDTH-WORD_WIDTH-1:0]};
                            mem_req_o <= 1'b0;
                            state     <= IFILL_RESP;
                        end
                    end
                end
                IFILL_DRAIN: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        state     <= IFILL_IDLE;
                    end
                end
                IFILL_RESP: begin
                    state <= IFILL_IDLE;
                end
                default: begin
                    state <= IFILL_IDLE;
                end
            endcase
        end
    end

    assign mem_addr_o = {base, beat, 2'b00};

    // ack must honour a kill arriving in the RESP cycle itself, so it is
    // qualified combinationally with the live request.
    assign mem2icache_o.ack    = (state == IFILL_RESP) & icache2mem_i.req & ~icache2mem_i.kill;
    assign mem2icache_o.r_data = r_data_q;

endmodule
